// File: rtl/apu_pkg.sv
// Shared APU definitions: frequency limit, sweep timer reload value, sweep FSM states.
package apu_pkg;

   localparam logic [11:0] FREQ_MAX          = 12'd2047;
   localparam logic [3:0]  SWEEP_ZERO_RELOAD = 4'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      CHECK = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/ch1_sweep_calc.sv
// Channel 1 sweep adder: shadow +/- (shadow >> shift), 12 bits wide, with overflow flag.
module ch1_sweep_calc
   import apu_pkg::*;
(
   input  logic [10:0] shadow,
   input  logic [2:0]  shift,
   input  logic        negate,
   output logic [11:0] sum,
   output logic        ovf
);

   logic [10:0] delta;

   // Subtraction can never go below zero because delta <= shadow, so only the
   // additive direction can overflow.
   always_comb begin
      delta = shadow >> shift;
      if (negate) begin
         sum = {1'b0, shadow} - {1'b0, delta};
      end else begin
         sum = {1'b0, shadow} + {1'b0, delta};
      end
      ovf = !negate && (sum > FREQ_MAX);
   end

endmodule

// File: rtl/ch1_sweep.sv
// Channel 1 frequency sweep unit.
// Optional build macro CH1_SWEEP_NEG_QUIRK_EN: clearing negate after a sweep step
// that used negate disables the channel.
//
// state | meaning
// IDLE  | waiting for a timer expiry; CPU frequency writes reach acc_d
// CALC  | apply one sweep step, or flag overflow
// CHECK | re-evaluate the updated shadow for overflow without writing it
module ch1_sweep
   import apu_pkg::*;
(
   input  logic        dyfa_1mhz,
   input  logic        apu_reset,
   input  logic        sweep_tick,
   input  logic        ch1_restart,
   input  logic [6:0]  ff10_d,
   input  logic [10:0] freq_in,
   input  logic        freq_load,
   output logic [10:0] acc_d,
   output logic        freq_upd,
   output logic        ch1_sweep_off
);

   sweep_state_t state, state_nxt;
   logic [10:0]  shadow, shadow_nxt;
   logic [10:0]  acc_nxt;
   logic [3:0]   timer, timer_nxt;
   logic         sweep_en, sweep_en_nxt;
   logic         upd_nxt, off_nxt;
   logic [2:0]   period, shift;
   logic         negate;
   logic [3:0]   reload_val;
   logic [11:0]  sum;
   logic         ovf;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
   logic         neg_used, neg_used_nxt;
`endif

   assign period     = ff10_d[6:4];
   assign negate     = ff10_d[3];
   assign shift      = ff10_d[2:0];
   assign reload_val = (period == 3'd0) ? SWEEP_ZERO_RELOAD : {1'b0, period};

   ch1_sweep_calc u_calc (
      .shadow (shadow),
      .shift  (shift),
      .negate (negate),
      .sum    (sum),
      .ovf    (ovf)
   );

   // Next-state and output decode; restart has priority over everything else.
   always_comb begin
      state_nxt    = state;
      shadow_nxt   = shadow;
      acc_nxt      = acc_d;
      timer_nxt    = timer;
      sweep_en_nxt = sweep_en;
      upd_nxt      = 1'b0;
      off_nxt      = ch1_sweep_off;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
      neg_used_nxt = neg_used;
`endif
      if (ch1_restart) begin
         shadow_nxt   = freq_in;
         acc_nxt      = freq_in;
         timer_nxt    = reload_val;
         off_nxt      = 1'b0;
         sweep_en_nxt = (period != 3'd0) || (shift != 3'd0);
         state_nxt    = (shift != 3'd0) ? CHECK : IDLE;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
         neg_used_nxt = 1'b0;
`endif
      end else begin
         // A timer of 0 (only seen straight after reset) expires like 1.
         if (sweep_tick) begin
            if (timer <= 4'd1) begin
               timer_nxt = reload_val;
               if (state == IDLE && sweep_en && period != 3'd0 && !ch1_sweep_off) begin
                  state_nxt = CALC;
               end
            end else begin
               timer_nxt = timer - 4'd1;
            end
         end
         case (state)
            CALC: begin
               state_nxt = IDLE;
               if (ovf) begin
                  off_nxt = 1'b1;
               end else if (shift != 3'd0) begin
                  shadow_nxt = sum[10:0];
                  acc_nxt    = sum[10:0];
                  upd_nxt    = 1'b1;
                  state_nxt  = CHECK;
               end
`ifdef CH1_SWEEP_NEG_QUIRK_EN
               if (negate) neg_used_nxt = 1'b1;
`endif
            end
            CHECK: begin
               state_nxt = IDLE;
               if (ovf) off_nxt = 1'b1;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
               if (negate) neg_used_nxt = 1'b1;
`endif
            end
            default: begin
               if (freq_load) acc_nxt = freq_in;
            end
         endcase
`ifdef CH1_SWEEP_NEG_QUIRK_EN
         if (neg_used && !negate) off_nxt = 1'b1;
`endif
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge dyfa_1mhz or posedge apu_reset) begin
      if (apu_reset) begin
         state         <= IDLE;
         shadow        <= '0;
         acc_d         <= '0;
         timer         <= '0;
         sweep_en      <= 1'b0;
         freq_upd      <= 1'b0;
         ch1_sweep_off <= 1'b0;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
         neg_used      <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         shadow        <= shadow_nxt;
         acc_d         <= acc_nxt;
         timer         <= timer_nxt;
         sweep_en      <= sweep_en_nxt;
         freq_upd      <= upd_nxt;
         ch1_sweep_off <= off_nxt;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
         neg_used      <= neg_used_nxt;
`endif
      end
   end

endmodule

// File: doc/ch1_sweep.md
CH1_SWEEP -- requirements
Module: ch1_sweep

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning (clock and reset first):
- dyfa_1mhz  in  1  APU clock; all state changes on its rising edge.
- apu_reset  in  1  asynchronous, active-high reset.
- sweep_tick  in  1  128 Hz frame-sequencer enable, one clock wide.
- ch1_restart  in  1  NR14 trigger pulse, one clock wide.
- ff10_d  in  7  NR10 fields, true polarity: [6:4] period, [3] negate, [2:0] shift.
- freq_in  in  11  NR14[2:0]:NR13 frequency as currently written.
- freq_load  in  1  pulse; a CPU write to NR13/NR14 occurred.
- acc_d  out  11  frequency fed to the ch1 frequency counter load inputs.
- freq_upd  out  1  one-clock pulse when acc_d takes a swept value.
- ch1_sweep_off  out  1  sweep overflow; disables channel 1.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-high.

Function
REQ-003 Internal state SHALL be: shadow[10:0], timer[3:0], sweep_en, state in {IDLE, CALC, CHECK}, and neg_used (quirk only, see REQ-016).
REQ-004 sum SHALL be shadow + (shadow >> shift) when negate=0 and shadow - (shadow >> shift) when negate=1, computed 12 bits wide; ovf SHALL be (negate=0 and sum > 2047).
REQ-005 On ch1_restart, at that edge: shadow and acc_d <= freq_in; timer <= period (0 loads 8); ch1_sweep_off <= 0; sweep_en <= (period != 0 or shift != 0); state <= CHECK if shift != 0, else IDLE.
REQ-006 On sweep_tick in IDLE with no restart: timer decrements; on 1->0, timer reloads period (0 loads 8); state <= CALC if sweep_en and period != 0.
REQ-007 Leaving CALC: if ovf, ch1_sweep_off <= 1 and state <= IDLE; else if shift != 0, shadow and acc_d <= sum[10:0], freq_upd pulses, and state <= CHECK; else state <= IDLE.
REQ-008 Leaving CHECK: ch1_sweep_off <= 1 if ovf (using the updated shadow); state <= IDLE; shadow and acc_d are unchanged.
REQ-009 Latency: a tick at edge N that expires the timer SHALL make a new acc_d and freq_upd visible after edge N+1; an overflow found in the second check SHALL be visible after edge N+2.
REQ-010 sweep_tick while state != IDLE SHALL still decrement or reload timer but SHALL NOT start a calculation.
REQ-011 freq_load in IDLE SHALL set acc_d <= freq_in and leave shadow unchanged; in CALC or CHECK, the swept update SHALL win.
REQ-012 ch1_restart SHALL override a simultaneous sweep_tick, freq_load, or in-flight CALC/CHECK.
REQ-013 Once ch1_sweep_off=1, it SHALL hold until ch1_restart or apu_reset; acc_d SHALL NOT change on ticks while it holds.
REQ-014 Subtraction SHALL never flag an overflow; shadow=0 SHALL stay 0.

Reset
REQ-015 While apu_reset=1: acc_d=0, shadow=0, timer=0, sweep_en=0, neg_used=0, freq_upd=0, ch1_sweep_off=0, state=IDLE, regardless of the clock; reset asserted mid-CALC SHALL abort the calculation with no update.

Configuration
REQ-016 Macro CH1_SWEEP_NEG_QUIRK_EN: when defined, neg_used SHALL be set by any CALC/CHECK performed with negate=1 and cleared by ch1_restart, and negate=0 with neg_used=1 SHALL set ch1_sweep_off at the next edge; when undefined, neg_used SHALL not exist and negate changes SHALL have no side effect.

Structure
REQ-017 A shared package apu_pkg SHALL hold FREQ_MAX=2047, SWEEP_ZERO_RELOAD=8, and the sweep state enum.
REQ-018 One sub-module, ch1_sweep_calc, SHALL be purely combinational: inputs shadow, shift, negate; outputs sum and ovf. It is instantiated once.

Verification
REQ-019 Restart freq 0x400, period 1, shift 1, negate 0 -> no overflow after CHECK; first expiring tick -> acc_d=0x600 with freq_upd, then CHECK sees 0x900 and sets ch1_sweep_off.
REQ-020 Restart freq 0x7FF, shift 1 -> ch1_sweep_off=1 one edge after restart; acc_d stays 0x7FF.
REQ-021 Negate 1, shift 2, period 2, freq 0x100 -> acc_d 0x0C0 after the 2nd tick and 0x090 after the 4th; ch1_sweep_off stays 0.
REQ-022 Period 0, shift 0, 20 ticks -> acc_d constant, freq_upd never pulses; freq_load 0x123 -> acc_d=0x123.
REQ-023 apu_reset pulsed while in CALC -> every output 0 immediately; the next restart behaves as in REQ-019.
REQ-024 Quirk: negate 1 with a completed calculation, then negate cleared -> ch1_sweep_off=1 next edge with CH1_SWEEP_NEG_QUIRK_EN defined, stays 0 without it.
